// File: rtl/spi_slave_param.sv
// SPI slave front-end: MOSI frames of {cmd[1:0], payload} are deserialised into rx_data,
// and RAM read data is serialised back on MISO.
module spi_slave_param #(
    parameter  int DATA_W     = 8,
    parameter  int TX_TIMEOUT = 16,
    localparam int FRAME_W    = DATA_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               busy,
    output logic               err
);

    localparam int CNT_W  = $clog2(FRAME_W);
    localparam int WAIT_W = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TX_TIMEOUT > 0) ? WAIT_W'(TX_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_CMD,
        S_WRITE,
        S_READ_ADD,
        S_READ_DATA,
        S_RD_WAIT,
        S_RD_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FRAME_W-2:0]  r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [WAIT_W-1:0]   r_wait;
    logic [DATA_W-1:0]   r_tx;
    logic                r_miso;
    logic [FRAME_W-1:0]  r_rx_data;
    logic                r_rx_valid;
    logic                r_err;
    logic                r_rd_addr_seen;

    logic [FRAME_W-1:0]  w_frame;
    logic [1:0]          w_cmd;
    logic                w_shift_en;
    logic                w_rx_load;
    logic                w_err;
    logic                w_set_seen;
    logic                w_clr_seen;
    logic                w_tx_latch;
    logic                w_abort;

    // The bit sampled on the current edge completes the frame.
    assign w_frame = {r_shift, MOSI};
    assign w_cmd   = w_frame[FRAME_W-1:FRAME_W-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_rx_load   = 1'b0;
        w_err       = 1'b0;
        w_set_seen  = 1'b0;
        w_clr_seen  = 1'b0;
        w_tx_latch  = 1'b0;
        w_abort     = 1'b0;
        if (SS_n && r_state != S_IDLE && r_state != S_DONE) begin
            w_abort     = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!SS_n) w_state_nxt = S_CHK_CMD;
                end
                S_CHK_CMD: begin
                    w_shift_en = 1'b1;
                    if (!MOSI)               w_state_nxt = S_WRITE;
                    else if (r_rd_addr_seen) w_state_nxt = S_READ_DATA;
                    else                     w_state_nxt = S_READ_ADD;
                end
                S_WRITE, S_READ_ADD, S_READ_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_cnt == '0) begin
                        if ((r_state == S_READ_ADD  && w_cmd != 2'b10) ||
                            (r_state == S_READ_DATA && w_cmd != 2'b11)) begin
                            w_err       = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_rx_load   = 1'b1;
                            w_set_seen  = (r_state == S_READ_ADD);
                            w_state_nxt = (r_state == S_READ_DATA) ? S_RD_WAIT : S_DONE;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (tx_valid) begin
                        w_tx_latch  = 1'b1;
                        w_state_nxt = S_RD_SHIFT;
                    end else if (TX_TIMEOUT != 0 && r_wait == WAIT_LAST) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_RD_SHIFT: begin
                    if (r_cnt == '0) begin
                        w_clr_seen  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (SS_n) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift        <= '0;
            r_cnt          <= '0;
            r_wait         <= '0;
            r_tx           <= '0;
            r_miso         <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_err          <= 1'b0;
            r_rd_addr_seen <= 1'b0;
        end else begin
            if (w_shift_en) r_shift <= {r_shift[FRAME_W-3:0], MOSI};

            // One counter serves both the inbound frame and the outbound read byte.
            if (r_state == S_CHK_CMD)  r_cnt <= CNT_W'(FRAME_W - 2);
            else if (w_tx_latch)       r_cnt <= CNT_W'(DATA_W - 1);
            else if (r_cnt != '0)      r_cnt <= r_cnt - 1'b1;

            if (r_state == S_RD_WAIT && !tx_valid) r_wait <= r_wait + 1'b1;
            else                                   r_wait <= '0;

            if (w_tx_latch)                  r_tx <= tx_data;
            else if (r_state == S_RD_SHIFT)  r_tx <= r_tx << 1;

            if (w_tx_latch)
                r_miso <= tx_data[DATA_W-1];
            else if (r_state == S_RD_SHIFT && !w_abort && r_cnt != '0)
                r_miso <= r_tx[DATA_W-2];
            else
                r_miso <= 1'b0;

            if (w_rx_load) r_rx_data <= w_frame;
            r_rx_valid <= w_rx_load;
            r_err      <= w_err;

            if (w_set_seen)      r_rd_addr_seen <= 1'b1;
            else if (w_clr_seen) r_rd_addr_seen <= 1'b0;
        end
    end

    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign err      = r_err;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed vector bench for spi_slave_param: an 8-bit instance (short timeout) and a 16-bit instance.
module tb_spi_slave_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss8_n, ss16_n, mosi, txv;
    logic [7:0]  txd8;
    logic [15:0] txd16;
    logic        miso8, rxv8, busy8, err8;
    logic [9:0]  rxd8;
    logic        miso16, rxv16, busy16, err16;
    logic [17:0] rxd16;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(4)) dut8 (
        .clk(clk), .rst(rst), .SS_n(ss8_n), .MOSI(mosi), .MISO(miso8),
        .rx_data(rxd8), .rx_valid(rxv8), .tx_data(txd8), .tx_valid(txv),
        .busy(busy8), .err(err8)
    );

    spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(16)) dut16 (
        .clk(clk), .rst(rst), .SS_n(ss16_n), .MOSI(mosi), .MISO(miso16),
        .rx_data(rxd16), .rx_valid(rxv16), .tx_data(txd16), .tx_valid(txv),
        .busy(busy16), .err(err16)
    );

    typedef struct {
        logic       ss;
        logic       mosi;
        logic       txv;
        logic [7:0] txd;
        logic       rxv;
        logic       err;
        logic       miso;
        logic       busy;
        logic [9:0] rxd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic ss, input logic mo, input logic tv, input logic [7:0] td,
                     input logic e_rxv, input logic e_err, input logic e_miso,
                     input logic e_busy, input logic [9:0] e_rxd);
        vec_t e;
        e.ss = ss; e.mosi = mo; e.txv = tv; e.txd = td;
        e.rxv = e_rxv; e.err = e_err; e.miso = e_miso; e.busy = e_busy; e.rxd = e_rxd;
        tbl.push_back(e);
    endtask

    // First n frame bits, MSB first; none of them completes the frame.
    task automatic bits(input logic [9:0] f, input int n, input logic [9:0] rxd);
        for (int i = 0; i < n; i++) v(1'b0, f[9-i], 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, rxd);
    endtask

    initial begin
        logic [6:0]  ms;
        logic [9:0]  f8;
        logic [17:0] f16;

        rst = 1'b1; ss8_n = 1'b1; ss16_n = 1'b1; mosi = 1'b0; txv = 1'b0;
        txd8 = 8'h00; txd16 = 16'h0000;
        #1;
        chk("reset miso8", miso8, 0);     chk("reset rx_valid8", rxv8, 0);
        chk("reset rx_data8", rxd8, 0);   chk("reset err8", err8, 0);
        chk("reset busy8", busy8, 0);     chk("reset busy16", busy16, 0);
        chk("reset rx_data16", rxd16, 0); chk("reset miso16", miso16, 0);
        tick(); tick();
        rst = 1'b0;

        // A: write address 00_1010_0101
        v(0,0,0,8'h00, 0,0,0,1, 10'h000);
        bits(10'h0A5, 9, 10'h000);
        v(0,1,0,8'h00, 1,0,0,1, 10'h0A5);
        v(0,0,0,8'h00, 0,0,0,1, 10'h0A5);
        v(1,0,0,8'h00, 0,0,0,0, 10'h0A5);
        // B: read address 10_0000_0011
        v(0,0,0,8'h00, 0,0,0,1, 10'h0A5);
        bits(10'h203, 9, 10'h0A5);
        v(0,1,0,8'h00, 1,0,0,1, 10'h203);
        v(1,0,0,8'h00, 0,0,0,0, 10'h203);
        // C: read data 11_0101_0101, RAM answers 0xC3 on the third wait edge
        v(0,0,0,8'h00, 0,0,0,1, 10'h203);
        bits(10'h355, 9, 10'h203);
        v(0,1,0,8'h00, 1,0,0,1, 10'h355);
        v(0,0,0,8'h00, 0,0,0,1, 10'h355);
        v(0,0,0,8'h00, 0,0,0,1, 10'h355);
        v(0,0,1,8'hC3, 0,0,1,1, 10'h355);
        ms = 7'b1000011;
        v(0,0,1,8'h00, 0,0,ms[6],1, 10'h355);
        for (int i = 5; i >= 0; i--) v(0,0,0,8'h00, 0,0,ms[i],1, 10'h355);
        v(0,0,0,8'h00, 0,0,0,1, 10'h355);
        v(0,0,0,8'h00, 0,0,0,1, 10'h355);
        v(1,0,0,8'h00, 0,0,0,0, 10'h355);
        // D: read flag cleared, so 10_1111_0000 is a legal read address
        v(0,0,0,8'h00, 0,0,0,1, 10'h355);
        bits(10'h2F0, 9, 10'h355);
        v(0,0,0,8'h00, 1,0,0,1, 10'h2F0);
        v(1,0,0,8'h00, 0,0,0,0, 10'h2F0);
        // E: command mismatch, 10 while a read address is pending
        v(0,0,0,8'h00, 0,0,0,1, 10'h2F0);
        bits(10'h201, 9, 10'h2F0);
        v(0,1,0,8'h00, 0,1,0,1, 10'h2F0);
        v(1,0,0,8'h00, 0,0,0,0, 10'h2F0);
        // F: read data with no tx_valid: timeout on the fourth wait edge
        v(0,0,0,8'h00, 0,0,0,1, 10'h2F0);
        bits(10'h300, 9, 10'h2F0);
        v(0,0,0,8'h00, 1,0,0,1, 10'h300);
        v(0,0,0,8'h00, 0,0,0,1, 10'h300);
        v(0,0,0,8'h00, 0,0,0,1, 10'h300);
        v(0,0,0,8'h00, 0,0,0,1, 10'h300);
        v(0,0,0,8'h00, 0,1,0,1, 10'h300);
        v(1,0,0,8'h00, 0,0,0,0, 10'h300);
        // G: flag survived the timeout, so 11 is accepted; abort beats tx_valid
        v(0,0,0,8'h00, 0,0,0,1, 10'h300);
        bits(10'h301, 9, 10'h300);
        v(0,1,0,8'h00, 1,0,0,1, 10'h301);
        v(1,0,1,8'hFF, 0,1,0,0, 10'h301);
        // H: abort after 5 bits of a write frame
        v(0,0,0,8'h00, 0,0,0,1, 10'h301);
        bits(10'h0FF, 5, 10'h301);
        v(1,0,0,8'h00, 0,1,0,0, 10'h301);
        v(1,0,0,8'h00, 0,0,0,0, 10'h301);

        foreach (tbl[i]) begin
            ss8_n = tbl[i].ss; mosi = tbl[i].mosi; txv = tbl[i].txv; txd8 = tbl[i].txd;
            tick();
            chk($sformatf("v%0d rx_valid", i), rxv8,  tbl[i].rxv);
            chk($sformatf("v%0d err", i),      err8,  tbl[i].err);
            chk($sformatf("v%0d miso", i),     miso8, tbl[i].miso);
            chk($sformatf("v%0d busy", i),     busy8, tbl[i].busy);
            chk($sformatf("v%0d rx_data", i),  rxd8,  tbl[i].rxd);
        end

        // Asynchronous reset in the middle of RD_SHIFT
        ss8_n = 1'b0; txv = 1'b0; tick();
        f8 = 10'h3AA;
        for (int i = 9; i >= 0; i--) begin mosi = f8[i]; tick(); end
        chk("rs rx_valid", rxv8, 1);
        chk("rs rx_data", rxd8, 10'h3AA);
        txv = 1'b1; txd8 = 8'hFF; tick();
        chk("rs miso bit7", miso8, 1);
        txv = 1'b0; tick();
        chk("rs miso bit6", miso8, 1);
        #2 rst = 1'b1;
        #1;
        chk("rs async miso", miso8, 0);
        chk("rs async busy", busy8, 0);
        chk("rs async rx_data", rxd8, 0);
        chk("rs async rx_valid", rxv8, 0);
        chk("rs async err", err8, 0);
        ss8_n = 1'b1;
        #1 rst = 1'b0;
        tick();
        // Reset cleared the read flag: 11 now lands in READ_ADD and mismatches
        ss8_n = 1'b0; tick();
        f8 = 10'h300;
        for (int i = 9; i >= 1; i--) begin mosi = f8[i]; tick(); end
        mosi = f8[0]; tick();
        chk("post-reset err", err8, 1);
        chk("post-reset rx_valid", rxv8, 0);
        ss8_n = 1'b1; tick();
        chk("post-reset idle", busy8, 0);

        // 16-bit payload: rx_valid after bit 18 only
        ss16_n = 1'b0; tick();
        chk("w16 busy", busy16, 1);
        f16 = 18'h01234;
        for (int i = 17; i >= 1; i--) begin mosi = f16[i]; tick(); end
        chk("w16 rx_valid early", rxv16, 0);
        mosi = f16[0]; tick();
        chk("w16 rx_valid", rxv16, 1);
        chk("w16 rx_data", rxd16, 18'h01234);
        chk("w16 err", err16, 0);
        ss16_n = 1'b1; tick();
        chk("w16 rx_valid pulse", rxv16, 0);
        chk("w16 idle", busy16, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
